// File: rtl/pmem_arb_pkg.sv
// Shared types and line/beat geometry for the pmem arbiter.
// Used by cacheline_adaptor and pmem_arbiter.
package pmem_arb_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } arb_state_t;

    typedef enum logic {
        CL_I,
        CL_D
    } client_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Line buffer, beat counter and beat mux/demux between a cache line
// and the 64-bit burst port. load fills the buffer, start marks a burst.
module cacheline_adaptor
    import pmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              start,
    input  logic              rd_mode,
    input  logic              pmem_resp,
    input  logic [BEAT_W-1:0] pmem_rdata,
    output logic [BEAT_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] line,
    output logic              done
);

    logic [CNT_W-1:0] cnt;
    logic             beat;

    // Strobes outside a burst never reach the counter or buffer.
    assign beat = start & pmem_resp;
    assign done = beat & (cnt == CNT_W'(BEATS - 1));

    assign pmem_wdata = line[cnt*BEAT_W +: BEAT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            line <= '0;
        end else begin
            if (load) begin
                line <= load_line;
            end else if (beat && rd_mode) begin
                line[cnt*BEAT_W +: BEAT_W] <= pmem_rdata;
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port.
// Define PMEM_ARB_RR_EN for round-robin; default is dcache-first.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state;
    client_t           client;
    client_t           gnt;
    logic              d_req;
    logic              any_req;
    logic              load;
    logic              done;
    logic [ADDR_W-1:0] gnt_addr;
    logic [LINE_W-1:0] line;

`ifdef PMEM_ARB_RR_EN
    client_t last_grant;

    always_comb begin
        d_req = d_read | d_write;
        if (d_req && i_read) begin
            gnt = (last_grant == CL_I) ? CL_D : CL_I;
        end else begin
            gnt = d_req ? CL_D : CL_I;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= CL_I;
        end else if (state == IDLE && any_req) begin
            last_grant <= gnt;
        end
    end
`else
    always_comb begin
        d_req = d_read | d_write;
        gnt   = d_req ? CL_D : CL_I;
    end
`endif

    assign any_req  = d_req | i_read;
    assign gnt_addr = (gnt == CL_D) ? d_addr : i_addr;
    assign load     = (state == IDLE) & any_req
                    & (gnt == CL_D) & d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            client       <= CL_I;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        client       <= gnt;
                        pmem_address <= {gnt_addr[ADDR_W-1:OFF_W],
                                         OFF_W'(0)};
                        // A write-back wins over a read on the same client.
                        if (gnt == CL_D && d_write) begin
                            pmem_write <= 1'b1;
                            state      <= WR_BURST;
                        end else begin
                            pmem_read <= 1'b1;
                            state     <= RD_BURST;
                        end
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (done) begin
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_address <= '0;
                        i_resp       <= (client == CL_I);
                        d_resp       <= (client == CL_D);
                        state        <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cacheline_adaptor u_adapt (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_line  (d_wdata),
        .start      (pmem_read | pmem_write),
        .rd_mode    (pmem_read),
        .pmem_resp  (pmem_resp),
        .pmem_rdata (pmem_rdata),
        .pmem_wdata (pmem_wdata),
        .line       (line),
        .done       (done)
    );

    assign i_rdata = line;
    assign d_rdata = line;

    illegal_rw: assert property (
        @(posedge clk) disable iff (rst) !(d_read && d_write)
    );

endmodule
